// File: rtl/m68k_bus_responder.sv
// 68000 bus target: synchronizes the strobes of an asynchronous bus cycle and
// answers hits in its address window from a local word store with DTACK_n/BERR_n.
module m68k_bus_responder #(
  parameter logic [23:0] BASE_ADDR   = 24'hE80000,
  parameter int          ADDR_BITS   = 8,
  parameter int          WAIT_CYCLES = 4
) (
  input  logic        PI_CLK,
  input  logic        RESET,
  input  logic [23:1] M68K_A,
  input  logic        M68K_AS_n,
  input  logic        M68K_UDS_n,
  input  logic        M68K_LDS_n,
  input  logic        M68K_RW,
  input  logic [15:0] M68K_D_IN,
  output logic [15:0] M68K_D_OUT,
  output logic        M68K_D_OE,
  output logic        M68K_DTACK_n,
  output logic        M68K_BERR_n,
  input  logic        WP,
  output logic        BUSY,
  output logic [15:0] ACCESS_CNT
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_MISS} state_t;

  state_t state, next_state;

  logic [1:0] as_sync, uds_sync, lds_sync;
  logic       as_s, uds_s, lds_s;

  logic [ADDR_BITS-1:0] idx_q;
  logic                 rw_q, uds_q, lds_q, err_q;
  logic [15:0]          din_q, dout_q, cnt_q;
  logic [3:0]           wait_cnt;

  logic [15:0] store [2**ADDR_BITS];

  logic request, hit, ack_entry, write_ok;

  // Strobes are the only asynchronous inputs that need synchronizing; address,
  // direction and write data are already stable by the time a strobe is seen.
  always_ff @(posedge PI_CLK or posedge RESET) begin
    if (RESET) begin
      as_sync  <= 2'b11;
      uds_sync <= 2'b11;
      lds_sync <= 2'b11;
    end else begin
      as_sync  <= {as_sync[0], M68K_AS_n};
      uds_sync <= {uds_sync[0], M68K_UDS_n};
      lds_sync <= {lds_sync[0], M68K_LDS_n};
    end
  end

  assign as_s  = as_sync[1];
  assign uds_s = uds_sync[1];
  assign lds_s = lds_sync[1];

  assign request   = !as_s && (!uds_s || !lds_s);
  assign hit       = M68K_A[23:ADDR_BITS+1] == BASE_ADDR[23:ADDR_BITS+1];
  assign ack_entry = (state == S_WAIT) && (next_state == S_ACK);
  assign write_ok  = !rw_q && !WP;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge PI_CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state gets a default first so no path through the case infers a latch.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (request) next_state = hit ? S_WAIT : S_MISS;
      S_WAIT: begin
        if (as_s)                next_state = S_IDLE;
        else if (wait_cnt == '0) next_state = S_ACK;
      end
      S_ACK:  if (as_s) next_state = S_IDLE;
      S_MISS: if (as_s) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge PI_CLK or posedge RESET) begin
    if (RESET) begin
      idx_q    <= '0;
      rw_q     <= 1'b1;
      uds_q    <= 1'b1;
      lds_q    <= 1'b1;
      din_q    <= '0;
      dout_q   <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (state == S_IDLE && request) begin
        idx_q    <= M68K_A[ADDR_BITS:1];
        rw_q     <= M68K_RW;
        uds_q    <= uds_s;
        lds_q    <= lds_s;
        din_q    <= M68K_D_IN;
        wait_cnt <= 4'(WAIT_CYCLES);
        if (hit && M68K_RW) dout_q <= store[M68K_A[ADDR_BITS:1]];
      end
      if (state == S_WAIT && wait_cnt != '0) wait_cnt <= wait_cnt - 4'd1;
      if (ack_entry) begin
        err_q <= !rw_q && WP;
        if (rw_q || !WP) cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  // NOTE: the store is deliberately left out of reset so it can map onto RAM.
  always_ff @(posedge PI_CLK) begin
    if (ack_entry && write_ok) begin
      if (!uds_q) store[idx_q][15:8] <= din_q[15:8];
      if (!lds_q) store[idx_q][7:0]  <= din_q[7:0];
    end
  end

  // Bus drivers decode straight from the state register so reset releases them at once.
  always_comb begin
    BUSY         = state != S_IDLE;
    M68K_D_OE    = rw_q && (state == S_WAIT || state == S_ACK);
    M68K_DTACK_n = !(state == S_ACK && !err_q);
    M68K_BERR_n  = !(state == S_ACK && err_q);
    M68K_D_OUT   = dout_q;
    ACCESS_CNT   = cnt_q;
  end

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Self-checking bench for m68k_bus_responder: bus-cycle driver with an edge-timing
// model of the expected pins, a word-store model, and a per-cycle output compare.
module tb_m68k_bus_responder;

  localparam int N = 4;

  logic        PI_CLK = 1'b0;
  logic        RESET  = 1'b1;
  logic [23:1] M68K_A = '0;
  logic        M68K_AS_n = 1'b1, M68K_UDS_n = 1'b1, M68K_LDS_n = 1'b1;
  logic        M68K_RW = 1'b1;
  logic [15:0] M68K_D_IN = '0;
  logic        WP = 1'b0;
  logic [15:0] M68K_D_OUT, ACCESS_CNT;
  logic        M68K_D_OE, M68K_DTACK_n, M68K_BERR_n, BUSY;

  m68k_bus_responder #(.BASE_ADDR(24'hE80000), .ADDR_BITS(8), .WAIT_CYCLES(N)) dut (
    .PI_CLK(PI_CLK), .RESET(RESET), .M68K_A(M68K_A), .M68K_AS_n(M68K_AS_n),
    .M68K_UDS_n(M68K_UDS_n), .M68K_LDS_n(M68K_LDS_n), .M68K_RW(M68K_RW),
    .M68K_D_IN(M68K_D_IN), .M68K_D_OUT(M68K_D_OUT), .M68K_D_OE(M68K_D_OE),
    .M68K_DTACK_n(M68K_DTACK_n), .M68K_BERR_n(M68K_BERR_n), .WP(WP),
    .BUSY(BUSY), .ACCESS_CNT(ACCESS_CNT)
  );

  always #5 PI_CLK = ~PI_CLK;

  // Expected pin values, advanced by the driver one edge at a time.
  logic        exp_dtack_n = 1'b1, exp_berr_n = 1'b1, exp_doe = 1'b0, exp_busy = 1'b0;
  logic [15:0] exp_cnt = '0, exp_dout = '0;
  logic [15:0] mem_m [256];

  int tests = 0, fails = 0;
  int edge_n = 0, dt_edge = 0, be_edge = 0;
  logic oe_seen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs are compared every cycle, 2 time units after the active edge.
  initial begin
    logic [35:0] act, exp;
    forever begin
      @(posedge PI_CLK);
      #2;
      act = {M68K_DTACK_n, M68K_BERR_n, M68K_D_OE, BUSY, ACCESS_CNT,
             exp_doe ? M68K_D_OUT : 16'h0};
      exp = {exp_dtack_n, exp_berr_n, exp_doe, exp_busy, exp_cnt,
             exp_doe ? exp_dout : 16'h0};
      check("outputs", act, exp);
    end
  end

  task automatic tick();
    @(posedge PI_CLK);
    #1;
    edge_n++;
    if (!M68K_DTACK_n && dt_edge == 0) dt_edge = edge_n;
    if (!M68K_BERR_n && be_edge == 0) be_edge = edge_n;
    if (M68K_D_OE) oe_seen = 1'b1;
  endtask

  task automatic release_bus();
    M68K_AS_n = 1'b1; M68K_UDS_n = 1'b1; M68K_LDS_n = 1'b1;
    tick(); tick(); tick();
    exp_dtack_n = 1'b1; exp_berr_n = 1'b1; exp_doe = 1'b0; exp_busy = 1'b0;
  endtask

  // mode: 0 = normal, 1 = abort during the wait phase, 2 = reset while acknowledged.
  // strb is {UDS_n, LDS_n}.
  task automatic bus_cycle(input logic [23:0] addr, input logic rw, input logic [1:0] strb,
                           input logic [15:0] din, input logic wp, input int mode,
                           input int sdelay, input int hold, output logic [15:0] rd);
    logic hit;
    int   idx;
    hit = (addr & 24'hFFFE00) == 24'hE80000;
    idx = int'(addr[8:1]);
    rd  = '0;
    M68K_A = addr[23:1]; M68K_RW = rw; M68K_D_IN = din; WP = wp;
    M68K_AS_n = 1'b0;
    repeat (sdelay) tick();
    M68K_UDS_n = strb[1]; M68K_LDS_n = strb[0];
    edge_n = 0; dt_edge = 0; be_edge = 0; oe_seen = 1'b0;
    tick(); tick(); tick();
    exp_busy = 1'b1;
    if (hit && rw) begin
      exp_doe  = 1'b1;
      exp_dout = mem_m[idx];
    end
    if (!hit) begin
      repeat (hold) tick();
      release_bus();
    end else if (mode == 1) begin
      tick();
      release_bus();
    end else begin
      repeat (N + 1) tick();
      if (!rw && wp) exp_berr_n = 1'b0;
      else begin
        exp_dtack_n = 1'b0;
        exp_cnt++;
        if (!rw) begin
          if (!strb[1]) mem_m[idx][15:8] = din[15:8];
          if (!strb[0]) mem_m[idx][7:0]  = din[7:0];
        end
      end
      rd = M68K_D_OUT;
      if (mode == 2) begin
        RESET = 1'b1;
        exp_dtack_n = 1'b1; exp_berr_n = 1'b1; exp_doe = 1'b0; exp_busy = 1'b0;
        exp_cnt = '0;
        tick(); tick();
        M68K_AS_n = 1'b1; M68K_UDS_n = 1'b1; M68K_LDS_n = 1'b1;
        RESET = 1'b0;
        tick(); tick(); tick();
      end else begin
        repeat (hold) tick();
        release_bus();
      end
    end
  endtask

  initial begin
    logic [15:0] rd;
    logic [23:0] addr;
    logic [1:0]  strb;
    logic        rw, hit;
    int          mode;

    repeat (3) tick();
    RESET = 1'b0;
    tick(); tick();

    // Word write then read back with fixed acknowledge timing.
    bus_cycle(24'hE80010, 1'b0, 2'b00, 16'h1234, 1'b0, 0, 0, 1, rd);
    check("wr_dtack_edge", dt_edge, N + 4);
    bus_cycle(24'hE80010, 1'b1, 2'b00, 16'h0000, 1'b0, 0, 0, 1, rd);
    check("rd_dtack_edge", dt_edge, 8);
    check("rd_word", rd, 16'h1234);
    check("cnt_two", ACCESS_CNT, 16'd2);

    // Fill the low part of the store so every later read is defined.
    for (int i = 0; i < 32; i++)
      if (i != 8)
        bus_cycle(24'hE80000 | 24'(i << 1), 1'b0, 2'b00, 16'($urandom), 1'b0, 0, 0, 0, rd);

    // Byte-lane writes.
    bus_cycle(24'hE80020, 1'b0, 2'b00, 16'h5566, 1'b0, 0, 0, 0, rd);
    bus_cycle(24'hE80020, 1'b0, 2'b10, 16'h00AB, 1'b0, 0, 2, 0, rd);
    bus_cycle(24'hE80020, 1'b1, 2'b10, 16'h0000, 1'b0, 0, 0, 0, rd);
    check("rd_lds_byte", rd, 16'h55AB);
    bus_cycle(24'hE80020, 1'b0, 2'b01, 16'hCD00, 1'b0, 0, 0, 2, rd);
    bus_cycle(24'hE80020, 1'b1, 2'b00, 16'h0000, 1'b0, 0, 0, 0, rd);
    check("rd_uds_byte", rd, 16'hCDAB);

    // Accesses outside the window are ignored.
    bus_cycle(24'hE90000, 1'b1, 2'b00, 16'h0000, 1'b0, 0, 0, 3, rd);
    check("miss_dtack", dt_edge, 0);
    check("miss_berr", be_edge, 0);
    check("miss_oe", oe_seen, 1'b0);
    bus_cycle(24'hE90000, 1'b0, 2'b00, 16'h7777, 1'b0, 0, 0, 1, rd);
    check("miss_wr_dtack", dt_edge, 0);

    // Write-protected write raises bus error and leaves the store alone.
    bus_cycle(24'hE80010, 1'b0, 2'b00, 16'hFFFF, 1'b1, 0, 0, 1, rd);
    check("wp_berr_edge", be_edge, 8);
    check("wp_dtack", dt_edge, 0);
    bus_cycle(24'hE80010, 1'b1, 2'b00, 16'h0000, 1'b1, 0, 0, 0, rd);
    check("wp_readback", rd, 16'h1234);

    // Aborted write: no acknowledge, no store change, next access served.
    bus_cycle(24'hE80010, 1'b0, 2'b00, 16'hBEEF, 1'b0, 1, 0, 0, rd);
    check("abort_dtack", dt_edge, 0);
    bus_cycle(24'hE80010, 1'b1, 2'b00, 16'h0000, 1'b0, 0, 0, 0, rd);
    check("abort_readback", rd, 16'h1234);
    check("abort_rd_edge", dt_edge, 8);

    // Reset asserted while acknowledged.
    bus_cycle(24'hE80010, 1'b1, 2'b00, 16'h0000, 1'b0, 2, 0, 0, rd);
    check("rst_cnt", ACCESS_CNT, 16'd0);
    bus_cycle(24'hE80010, 1'b0, 2'b01, 16'h9900, 1'b0, 0, 1, 0, rd);
    bus_cycle(24'hE80010, 1'b1, 2'b00, 16'h0000, 1'b0, 0, 0, 0, rd);
    check("post_rst_rd", rd, 16'h9934);
    check("post_rst_cnt", ACCESS_CNT, 16'd2);

    // Randomized traffic against the model.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 9) < 8)
        addr = 24'hE80000 | 24'($urandom_range(0, 15) << 1);
      else
        addr = ($urandom_range(0, 1) != 0) ? (24'hE90000 | 24'($urandom_range(0, 511)))
                                           : 24'($urandom) & 24'h7FFFFE;
      hit  = (addr & 24'hFFFE00) == 24'hE80000;
      rw   = $urandom_range(0, 1) != 0;
      case ($urandom_range(0, 2))
        0:       strb = 2'b00;
        1:       strb = 2'b01;
        default: strb = 2'b10;
      endcase
      mode = (hit && $urandom_range(0, 9) == 0) ? 1 : 0;
      bus_cycle(addr, rw, strb, 16'($urandom), $urandom_range(0, 4) == 0, mode,
                rw ? 0 : int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rd);
      repeat ($urandom_range(0, 2)) tick();
    end

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
